// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg
//   Shared constants and helpers for the tick generator.
//   CNT_W_DEF : default counter/divisor width.
//   MOVE_DIV  : reset divisor of the snake move channel (channel 0).
//   SCAN_DIV  : reset divisor of the display scan channel (channel 1).
//   ch_width  : width of a channel-select field, never narrower than 1 bit.
package tick_gen_pkg;

  localparam int          CNT_W_DEF = 24;
  localparam logic [23:0] MOVE_DIV  = 24'd8388608;
  localparam logic [23:0] SCAN_DIV  = 24'd16384;

  // A single-channel build still needs a 1-bit select port.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_chan.sv
// tick_chan
//   One tick channel: an up-counter with an active divisor and a pending
//   (not yet applied) divisor, producing a registered 1-cycle tick and a
//   square wave that toggles on every tick.
// Ports
//   clk     in  system clock
//   rst_n   in  synchronous reset, active low
//   en      in  count enable
//   clr     in  restart in phase (overrides en)
//   ld      in  divisor write strobe, stores ld_div as pending
//   ld_div  in  new divisor (0 behaves as 1)
//   tick    out registered 1-cycle tick
//   sq      out square wave, period 2*divisor
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_div,
  output logic             tick,
  output logic             sq
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;

  logic [CNT_W-1:0] last_cnt;
  logic [CNT_W-1:0] pend_last;
  logic             restart;

  // Next-state logic. A "restart" is any edge at which a new period may
  // begin: wrap, clear, or any disabled edge. Only then may a pending
  // divisor become active, so a running period always finishes with the
  // divisor it started with.
  always_comb begin
    last_cnt   = (div_q  == '0) ? '0 : div_q  - CNT_W'(1);
    pend_last  = (pend_q == '0) ? '0 : pend_q - CNT_W'(1);
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    tick_d     = 1'b0;
    sq_d       = sq_q;
    restart    = 1'b0;

    if (clr) begin
      cnt_d   = '0;
      sq_d    = 1'b0;
      restart = 1'b1;
    end else if (!en) begin
      restart = 1'b1;
    end else if (cnt_q == last_cnt) begin
      cnt_d   = '0;
      tick_d  = 1'b1;
      sq_d    = ~sq_q;
      restart = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (restart && pend_vld_q) begin
      div_d      = pend_q;
      pend_vld_d = 1'b0;
      // Applying a smaller divisor while disabled would leave the held
      // count beyond the new wrap point; restart the period instead.
      if (cnt_d > pend_last) begin
        cnt_d = '0;
      end
    end

    // A write on a restart edge is kept for the following restart.
    if (ld) begin
      pend_d     = ld_div;
      pend_vld_d = 1'b1;
    end
  end

  // State registers with synchronous reset to the build-time divisor.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      div_q      <= DIV_RST;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      tick_q     <= 1'b0;
      sq_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      tick_q     <= tick_d;
      sq_q       <= sq_d;
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;

endmodule

// File: rtl/tick_gen.sv
// tick_gen
//   Multi-channel programmable tick generator. Each channel emits a 1-cycle
//   tick every DIV clocks and a square wave toggling on each tick. Divisors
//   can be rewritten at run time through a small write port; new values take
//   effect at the next restart of the target channel.
// Ports
//   clk       in  system clock
//   rst_n     in  synchronous reset, active low
//   en        in  per-channel count enable
//   sync_clr  in  restart all channels in phase
//   cfg_we    in  1-cycle divisor write request
//   cfg_ch    in  target channel of the write
//   cfg_div   in  new divisor value
//   cfg_ack   out 1-cycle write acknowledge, one cycle after cfg_we
//   cfg_err   out with cfg_ack: channel out of range, write discarded
//   tick      out registered 1-cycle tick per channel
//   sq        out square wave per channel
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int                      NUM_CH   = 2,
  parameter int                      CNT_W    = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {SCAN_DIV, MOVE_DIV},
  parameter int                      CH_W     = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  // Channel count widened by one bit so the range test also works when
  // NUM_CH is a power of two.
  localparam logic [CH_W:0] NUM_CH_X = (CH_W+1)'(NUM_CH);

  logic [NUM_CH-1:0] ld;
  logic              ch_bad;
  logic              cfg_ack_q, cfg_ack_d;
  logic              cfg_err_q, cfg_err_d;

  // Write decode: one load strobe per channel; out-of-range selects hit no
  // channel and are flagged on the acknowledge.
  always_comb begin
    ld     = '0;
    ch_bad = ({1'b0, cfg_ch} >= NUM_CH_X);
    for (int i = 0; i < NUM_CH; i++) begin
      ld[i] = cfg_we && (cfg_ch == CH_W'(i));
    end
    cfg_ack_d = cfg_we;
    cfg_err_d = cfg_we && ch_bad;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_ack_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_ack_q <= cfg_ack_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_ack = cfg_ack_q;
  assign cfg_err = cfg_err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_chan #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_INIT[g*CNT_W +: CNT_W])
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en[g]),
      .clr    (sync_clr),
      .ld     (ld[g]),
      .ld_div (cfg_div),
      .tick   (tick[g]),
      .sq     (sq[g])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen
//   Bench for tick_gen (2 channels, 8-bit, reset divisors 4 and 6) plus a
//   3-channel instance used to exercise the out-of-range write flag.
//   Directed scenarios pin exact tick edges; a randomized phase compares
//   every cycle against a period-based reference model.
module tb_tick_gen;

  localparam int NCH = 2;
  localparam int CW  = 8;
  localparam int INIT_DIV [NCH] = '{4, 6};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NCH-1:0] en;
  logic          sync_clr;
  logic          cfg_we;
  logic [0:0]    cfg_ch;
  logic [CW-1:0] cfg_div;
  logic          cfg_ack, cfg_err;
  logic [NCH-1:0] tick, sq;

  logic          cfg_we3;
  logic [1:0]    cfg_ch3;
  logic [CW-1:0] cfg_div3;
  logic          cfg_ack3, cfg_err3;
  logic [2:0]    tick3, sq3;

  int checkCount = 0;
  int passCount  = 0;
  int edgeNum    = 0;

  // Reference model: elapsed cycles in the current period, active and
  // pending divisors, and the expected registered outputs.
  int elapsed [NCH];
  int mDiv    [NCH];
  int mPend   [NCH];
  bit mPendV  [NCH];
  bit mTick   [NCH];
  bit mSq     [NCH];
  bit mAck, mErr;

  always #5 clk = ~clk;

  tick_gen #(
    .NUM_CH   (NCH),
    .CNT_W    (CW),
    .DIV_INIT ({8'd6, 8'd4})
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sync_clr (sync_clr),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_ack  (cfg_ack),
    .cfg_err  (cfg_err),
    .tick     (tick),
    .sq       (sq)
  );

  tick_gen #(
    .NUM_CH   (3),
    .CNT_W    (CW),
    .DIV_INIT ({8'd5, 8'd3, 8'd4})
  ) u_dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (3'b000),
    .sync_clr (1'b0),
    .cfg_we   (cfg_we3),
    .cfg_ch   (cfg_ch3),
    .cfg_div  (cfg_div3),
    .cfg_ack  (cfg_ack3),
    .cfg_err  (cfg_err3),
    .tick     (tick3),
    .sq       (sq3)
  );

  task automatic check(input string name, input logic act, input logic exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s at edge %0d: got %b expected %b", name, edgeNum, act, exp);
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelEdge();
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        elapsed[i] = 0;
        mDiv[i]    = INIT_DIV[i];
        mPendV[i]  = 0;
        mTick[i]   = 0;
        mSq[i]     = 0;
      end
      mAck = 0;
      mErr = 0;
      return;
    end
    for (int i = 0; i < NCH; i++) begin
      int period;
      bit newPeriod;
      period    = (mDiv[i] < 1) ? 1 : mDiv[i];
      newPeriod = 0;
      mTick[i]  = 0;
      if (sync_clr) begin
        elapsed[i] = 0;
        mSq[i]     = 0;
        newPeriod  = 1;
      end else if (!en[i]) begin
        newPeriod = 1;
      end else if (elapsed[i] + 1 == period) begin
        elapsed[i] = 0;
        mTick[i]   = 1;
        mSq[i]     = !mSq[i];
        newPeriod  = 1;
      end else begin
        elapsed[i] = elapsed[i] + 1;
      end
      if (newPeriod && mPendV[i]) begin
        mDiv[i]   = mPend[i];
        mPendV[i] = 0;
        if (elapsed[i] >= ((mDiv[i] < 1) ? 1 : mDiv[i])) elapsed[i] = 0;
      end
    end
    mAck = cfg_we;
    mErr = cfg_we && (int'(cfg_ch) >= NCH);
    if (cfg_we && int'(cfg_ch) < NCH) begin
      mPend[cfg_ch]  = int'(cfg_div);
      mPendV[cfg_ch] = 1;
    end
  endtask

  task automatic checkOutput();
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("tick%0d", i), tick[i], mTick[i]);
      check($sformatf("sq%0d", i), sq[i], mSq[i]);
    end
    check("cfg_ack", cfg_ack, mAck);
    check("cfg_err", cfg_err, mErr);
  endtask

  // One clock: edge, model update, then sample 1 time unit later.
  task automatic applyStimulus();
    @(posedge clk);
    modelEdge();
    if (!rst_n) edgeNum = 0;
    else edgeNum++;
    #1;
    checkOutput();
  endtask

  // Hand-computed expectation checked against both the DUT and the model.
  task automatic pinTick(input string name, input int ch, input logic exp);
    check({name, "_dut"}, tick[ch], exp);
    check({name, "_model"}, mTick[ch], exp);
  endtask

  task automatic runTo(input int target);
    while (edgeNum < target) applyStimulus();
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = '0;
    sync_clr = 1'b0;
    cfg_we   = 1'b0;
    cfg_ch   = '0;
    cfg_div  = '0;
    cfg_we3  = 1'b0;
    cfg_ch3  = '0;
    cfg_div3 = '0;

    applyStimulus();
    applyStimulus();
    check("rst_tick", |tick, 1'b0);
    check("rst_sq", |sq, 1'b0);
    check("rst_ack", cfg_ack, 1'b0);

    // Reset release: ch0 ticks at 4,8,12; ch1 at 6,12.
    rst_n = 1'b1;
    en    = 2'b11;
    for (int e = 1; e <= 12; e++) begin
      applyStimulus();
      pinTick($sformatf("start_t0_e%0d", e), 0, (e == 4 || e == 8 || e == 12));
      pinTick($sformatf("start_t1_e%0d", e), 1, (e == 6 || e == 12));
      check($sformatf("start_sq0_e%0d", e), sq[0], ((e >= 4 && e < 8) || e >= 12));
      check($sformatf("start_sq1_e%0d", e), sq[1], (e >= 6 && e < 12));
    end

    // Hold ch0 for 3 cycles at count 2: its tick moves from 16 to 19.
    runTo(14);
    en = 2'b10;
    runTo(16);
    pinTick("hold_t0_e16", 0, 1'b0);
    runTo(17);
    en = 2'b11;
    runTo(18);
    pinTick("hold_t1_e18", 1, 1'b1);
    pinTick("hold_t0_e18", 0, 1'b0);
    runTo(19);
    pinTick("hold_t0_e19", 0, 1'b1);

    // Mid-count clear at edge 21; next ticks at 25 (ch0) and 27 (ch1).
    runTo(20);
    sync_clr = 1'b1;
    runTo(21);
    sync_clr = 1'b0;
    check("clr_tick", |tick, 1'b0);
    check("clr_sq", |sq, 1'b0);
    runTo(24);
    pinTick("clr_t0_e24", 0, 1'b0);
    runTo(25);
    pinTick("clr_t0_e25", 0, 1'b1);
    runTo(26);

    // Write ch0 div=2 at count 1: one more period of 4 (tick 29), then 2.
    cfg_we  = 1'b1;
    cfg_ch  = 1'b0;
    cfg_div = 8'd2;
    runTo(27);
    cfg_we = 1'b0;
    check("wr_ack", cfg_ack, 1'b1);
    check("wr_err", cfg_err, 1'b0);
    pinTick("clr_t1_e27", 1, 1'b1);
    runTo(28);
    check("wr_ack_drop", cfg_ack, 1'b0);
    pinTick("wr_t0_e28", 0, 1'b0);
    for (int e = 29; e <= 33; e++) begin
      runTo(e);
      pinTick($sformatf("wr_t0_e%0d", e), 0, (e == 29 || e == 31 || e == 33));
    end

    // Write ch1 div=0: old period ends at 39, then tick held high.
    cfg_we  = 1'b1;
    cfg_ch  = 1'b1;
    cfg_div = 8'd0;
    runTo(34);
    cfg_we = 1'b0;
    runTo(38);
    pinTick("d1_t1_e38", 1, 1'b0);
    for (int e = 39; e <= 41; e++) begin
      runTo(e);
      pinTick($sformatf("d1_t1_e%0d", e), 1, 1'b1);
    end

    // Pending write followed by a 1-cycle reset: initial divisors return.
    cfg_we  = 1'b1;
    cfg_ch  = 1'b0;
    cfg_div = 8'd7;
    runTo(42);
    cfg_we = 1'b0;
    rst_n  = 1'b0;
    applyStimulus();
    check("rst2_tick", |tick, 1'b0);
    check("rst2_sq", |sq, 1'b0);
    check("rst2_ack", cfg_ack, 1'b0);
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      applyStimulus();
      pinTick($sformatf("rst2_t0_e%0d", e), 0, (e == 4 || e == 8));
      pinTick($sformatf("rst2_t1_e%0d", e), 1, (e == 6));
    end

    // Out-of-range channel on the 3-channel instance.
    cfg_we3  = 1'b1;
    cfg_ch3  = 2'd3;
    cfg_div3 = 8'd9;
    applyStimulus();
    check("err3_ack", cfg_ack3, 1'b1);
    check("err3_err", cfg_err3, 1'b1);
    cfg_ch3 = 2'd2;
    applyStimulus();
    check("ok3_ack", cfg_ack3, 1'b1);
    check("ok3_err", cfg_err3, 1'b0);
    cfg_we3 = 1'b0;
    applyStimulus();
    check("idle3_ack", cfg_ack3, 1'b0);
    check("idle3_err", cfg_err3, 1'b0);

    // Randomized traffic; the model is checked on every cycle.
    for (int c = 0; c < 3000; c++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      en       = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      sync_clr = ($urandom_range(0, 39) == 0);
      cfg_we   = ($urandom_range(0, 5) == 0);
      cfg_ch   = 1'($urandom_range(0, 1));
      cfg_div  = CW'($urandom_range(0, 9));
      applyStimulus();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
